// File: rtl/regfile_wb_ctrl_if.sv
// Writeback bus between the two requesters, the write-port controller and the regfile.
// Latency: none (wires only).
// Backpressure: ready is driven by the controller's slave side and qualifies each valid.
interface regfile_wb_ctrl_if #(
    parameter int XLEN = 64,
    parameter int NREG = 32
);
    logic            alu_valid;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            alu_ready;
    logic            mem_valid;
    logic [4:0]      mem_rd;
    logic [XLEN-1:0] mem_data;
    logic            mem_ready;
    logic            reg_write;
    logic [4:0]      write_register;
    logic [XLEN-1:0] write_data;
    logic            init_done;
    logic [NREG-1:0] pending_mask;

    // Requester and regfile side.
    modport master (
        output alu_valid, alu_rd, alu_data,
        output mem_valid, mem_rd, mem_data,
        input  alu_ready, mem_ready,
        input  reg_write, write_register, write_data, init_done, pending_mask
    );

    // Write-port controller side.
    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  mem_valid, mem_rd, mem_data,
        output alu_ready, mem_ready,
        output reg_write, write_register, write_data, init_done, pending_mask
    );
endinterface

// File: rtl/regfile_wb_ctrl.sv
// Regfile write-port controller: clears x1..x31 after reset, then round-robins ALU/load writebacks.
// Latency: an accepted request is on the write port the cycle after the accepting edge.
// Backpressure: ready=0 during the clear and for the losing requester; no buffering past the output stage.
module regfile_wb_ctrl #(
    parameter int XLEN = 64,
    parameter int NREG = 32
) (
    input  logic                clk,
    input  logic                reset,
    regfile_wb_ctrl_if.slave    bus
);

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    state_t          r_state;
    logic [4:0]      r_cnt;
    logic            r_last_mem;     // 1: the last grant went to the load unit
    logic            r_reg_write;
    logic [4:0]      r_wr_reg;
    logic [XLEN-1:0] r_wr_data;
    logic            r_init_done;
    logic [NREG-1:0] r_pending;

    state_t          w_state_nxt;
    logic [4:0]      w_cnt_nxt;
    logic            w_last_mem_nxt;
    logic            w_reg_write_nxt;
    logic [4:0]      w_wr_reg_nxt;
    logic [XLEN-1:0] w_wr_data_nxt;
    logic            w_init_nxt;
    logic [NREG-1:0] w_pending_nxt;

    logic            w_run;
    logic            w_alu_rdy;
    logic            w_mem_rdy;
    logic            w_acc_alu;
    logic            w_acc_mem;

    // Round-robin grant: on a tie the requester that did not win last time goes first.
    always_comb begin
        w_run     = (r_state == S_RUN);
        w_alu_rdy = w_run & bus.alu_valid & (~bus.mem_valid | r_last_mem);
        w_mem_rdy = w_run & bus.mem_valid & (~bus.alu_valid | ~r_last_mem);
        w_acc_alu = bus.alu_valid & w_alu_rdy;
        w_acc_mem = bus.mem_valid & w_mem_rdy;
    end

    // Next-state and next output-stage contents.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_last_mem_nxt  = r_last_mem;
        w_reg_write_nxt = 1'b0;
        w_wr_reg_nxt    = r_wr_reg;
        w_wr_data_nxt   = r_wr_data;
        w_init_nxt      = r_init_done;
        case (r_state)
            S_CLEAR: begin
                w_reg_write_nxt = 1'b1;
                w_wr_reg_nxt    = r_cnt;
                w_wr_data_nxt   = '0;
                w_cnt_nxt       = r_cnt + 5'd1;
                if (r_cnt == 5'd31) begin
                    w_state_nxt = S_RUN;
                    w_init_nxt  = 1'b1;
                end
            end
            S_RUN: begin
                if (w_acc_alu) begin
                    w_last_mem_nxt = 1'b0;
                    // Writes to x0 are consumed but never reach the port.
                    if (bus.alu_rd != 5'd0) begin
                        w_reg_write_nxt = 1'b1;
                        w_wr_reg_nxt    = bus.alu_rd;
                        w_wr_data_nxt   = bus.alu_data;
                    end
                end else if (w_acc_mem) begin
                    w_last_mem_nxt = 1'b1;
                    if (bus.mem_rd != 5'd0) begin
                        w_reg_write_nxt = 1'b1;
                        w_wr_reg_nxt    = bus.mem_rd;
                        w_wr_data_nxt   = bus.mem_data;
                    end
                end
            end
            default: w_state_nxt = S_CLEAR;
        endcase
        w_pending_nxt = w_reg_write_nxt ? ({{(NREG-1){1'b0}}, 1'b1} << w_wr_reg_nxt) : '0;
    end

    // State register, clear counter and arbitration history.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_CLEAR;
            r_cnt      <= 5'd1;
            r_last_mem <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_last_mem <= w_last_mem_nxt;
        end
    end

    // Registered write-port stage with its pending mask.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_reg_write <= 1'b0;
            r_wr_reg    <= 5'd0;
            r_wr_data   <= '0;
            r_init_done <= 1'b0;
            r_pending   <= '0;
        end else begin
            r_reg_write <= w_reg_write_nxt;
            r_wr_reg    <= w_wr_reg_nxt;
            r_wr_data   <= w_wr_data_nxt;
            r_init_done <= w_init_nxt;
            r_pending   <= w_pending_nxt;
        end
    end

    assign bus.alu_ready      = w_alu_rdy;
    assign bus.mem_ready      = w_mem_rdy;
    assign bus.reg_write      = r_reg_write;
    assign bus.write_register = r_wr_reg;
    assign bus.write_data     = r_wr_data;
    assign bus.init_done      = r_init_done;
    assign bus.pending_mask   = r_pending;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed bench for regfile_wb_ctrl with a behavioural regfile on the write port.
// Latency: outputs sampled 1ns after each rising edge.
// Backpressure: ready is checked combinationally after inputs are driven.
module tb_regfile_wb_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   vecs = 0;
    int   errs = 0;
    logic [63:0] rf [32];

    regfile_wb_ctrl_if #(.XLEN(64), .NREG(32)) bus ();

    regfile_wb_ctrl #(.XLEN(64), .NREG(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural regfile: x0 hardwired, captures the port at each edge.
    always @(posedge clk) begin
        if (bus.reg_write && bus.write_register != 5'd0)
            rf[bus.write_register] <= bus.write_data;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.alu_valid = 1'b0; bus.alu_rd = 5'd0; bus.alu_data = 64'd0;
        bus.mem_valid = 1'b0; bus.mem_rd = 5'd0; bus.mem_data = 64'd0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd7;
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd8;
        #1;
        vecs++;
        if ({bus.reg_write, bus.write_register, bus.init_done, bus.alu_ready, bus.mem_ready} !== 9'd0) begin
            errs++; $display("FAIL reset_ctrl: got %b required 0", {bus.reg_write, bus.write_register, bus.init_done, bus.alu_ready, bus.mem_ready});
        end
        vecs++;
        if (bus.write_data !== 64'd0 || bus.pending_mask !== 32'd0) begin
            errs++; $display("FAIL reset_data: data %h mask %h required 0", bus.write_data, bus.pending_mask);
        end
        step();
        idle_inputs();
    endtask

    // Runs the 31-write clear; optionally expects a held ALU request to wait throughout.
    task automatic run_clear(input bit alu_held);
        reset = 1'b0;
        for (int i = 1; i <= 31; i++) begin
            vecs++;
            if (bus.alu_ready !== 1'b0 || bus.mem_ready !== 1'b0) begin
                errs++; $display("FAIL clear_ready step %0d: got %b%b required 00", i, bus.alu_ready, bus.mem_ready);
            end
            step();
            vecs++;
            if (bus.reg_write !== 1'b1 || bus.write_register !== 5'(i) || bus.write_data !== 64'd0 ||
                bus.pending_mask !== (32'd1 << i) || bus.init_done !== (i == 31)) begin
                errs++; $display("FAIL clear_write step %0d: we %b rd %0d data %h mask %h done %b required 1 %0d 0 %h %b",
                                 i, bus.reg_write, bus.write_register, bus.write_data, bus.pending_mask, bus.init_done,
                                 i, 32'd1 << i, (i == 31));
            end
        end
        vecs++;
        if (bus.alu_ready !== alu_held) begin
            errs++; $display("FAIL first_run_ready: got %b required %b", bus.alu_ready, alu_held);
        end
    endtask

    task automatic test_clear();
        run_clear(1'b0);
        step();
        vecs++;
        if (bus.reg_write !== 1'b0 || bus.pending_mask !== 32'd0) begin
            errs++; $display("FAIL post_clear_idle: we %b mask %h required 0 0", bus.reg_write, bus.pending_mask);
        end
        for (int r = 0; r < 32; r++) begin
            vecs++;
            if (rf[r] !== 64'd0) begin
                errs++; $display("FAIL clear_contents x%0d: got %h required 0", r, rf[r]);
            end
        end
    endtask

    task automatic test_alu_only();
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd1; bus.alu_data = 64'd5;
        #1;
        vecs++;
        if (bus.alu_ready !== 1'b1) begin errs++; $display("FAIL alu_ready1: got %b required 1", bus.alu_ready); end
        step();
        vecs++;
        if (bus.reg_write !== 1'b1 || bus.write_register !== 5'd1 || bus.write_data !== 64'd5) begin
            errs++; $display("FAIL alu_write1: we %b rd %0d data %h required 1 1 5", bus.reg_write, bus.write_register, bus.write_data);
        end
        bus.alu_rd = 5'd2; bus.alu_data = 64'd6;
        #1;
        vecs++;
        if (bus.alu_ready !== 1'b1) begin errs++; $display("FAIL alu_ready2: got %b required 1", bus.alu_ready); end
        step();
        vecs++;
        if (bus.reg_write !== 1'b1 || bus.write_register !== 5'd2 || bus.write_data !== 64'd6 || rf[1] !== 64'd5) begin
            errs++; $display("FAIL alu_write2: we %b rd %0d data %h x1 %h required 1 2 6 5", bus.reg_write, bus.write_register, bus.write_data, rf[1]);
        end
        idle_inputs();
        step();
        vecs++;
        if (bus.reg_write !== 1'b0 || bus.write_register !== 5'd2 || bus.write_data !== 64'd6 || rf[2] !== 64'd6) begin
            errs++; $display("FAIL alu_hold: we %b rd %0d data %h x2 %h required 0 2 6 6", bus.reg_write, bus.write_register, bus.write_data, rf[2]);
        end
    endtask

    task automatic test_mem_rd0();
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd0; bus.mem_data = 64'd8;
        #1;
        vecs++;
        if (bus.mem_ready !== 1'b1 || bus.alu_ready !== 1'b0) begin
            errs++; $display("FAIL rd0_ready: mem %b alu %b required 1 0", bus.mem_ready, bus.alu_ready);
        end
        step();
        idle_inputs();
        vecs++;
        if (bus.reg_write !== 1'b0 || bus.pending_mask !== 32'd0 || rf[0] !== 64'd0) begin
            errs++; $display("FAIL rd0_drop: we %b mask %h x0 %h required 0 0 0", bus.reg_write, bus.pending_mask, rf[0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] exp_rd [3];
        logic [63:0] exp_dat [3];
        exp_rd[0] = 5'd3; exp_rd[1] = 5'd4; exp_rd[2] = 5'd3;
        exp_dat[0] = 64'hA; exp_dat[1] = 64'hB; exp_dat[2] = 64'hA;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 64'hA;
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd4; bus.mem_data = 64'hB;
        for (int k = 0; k < 3; k++) begin
            #1;
            vecs++;
            if (bus.alu_ready !== (k != 1) || bus.mem_ready !== (k == 1)) begin
                errs++; $display("FAIL rr_grant %0d: alu %b mem %b required %b %b", k, bus.alu_ready, bus.mem_ready, (k != 1), (k == 1));
            end
            step();
            vecs++;
            if (bus.reg_write !== 1'b1 || bus.write_register !== exp_rd[k] || bus.write_data !== exp_dat[k] ||
                bus.pending_mask !== (32'd1 << exp_rd[k])) begin
                errs++; $display("FAIL rr_write %0d: we %b rd %0d data %h mask %h required 1 %0d %h %h",
                                 k, bus.reg_write, bus.write_register, bus.write_data, bus.pending_mask,
                                 exp_rd[k], exp_dat[k], 32'd1 << exp_rd[k]);
            end
        end
        idle_inputs();
        step();
        vecs++;
        if (bus.reg_write !== 1'b0 || bus.pending_mask !== 32'd0 || rf[3] !== 64'hA || rf[4] !== 64'hB) begin
            errs++; $display("FAIL rr_final: we %b mask %h x3 %h x4 %h required 0 0 a b", bus.reg_write, bus.pending_mask, rf[3], rf[4]);
        end
    endtask

    task automatic test_reset_mid();
        // Reset at clear step 10.
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 1; i <= 10; i++) step();
        vecs++;
        if (bus.write_register !== 5'd10 || bus.reg_write !== 1'b1) begin
            errs++; $display("FAIL step10: rd %0d we %b required 10 1", bus.write_register, bus.reg_write);
        end
        reset = 1'b1;
        #1;
        vecs++;
        if (bus.reg_write !== 1'b0 || bus.pending_mask !== 32'd0 || bus.init_done !== 1'b0) begin
            errs++; $display("FAIL mid_clear_reset: we %b mask %h done %b required 0 0 0", bus.reg_write, bus.pending_mask, bus.init_done);
        end
        step();
        // Request held during the restarted clear is granted in the first RUN cycle.
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 64'h77;
        run_clear(1'b1);
        step();
        vecs++;
        if (bus.reg_write !== 1'b1 || bus.write_register !== 5'd5 || bus.write_data !== 64'h77) begin
            errs++; $display("FAIL held_req: we %b rd %0d data %h required 1 5 77", bus.reg_write, bus.write_register, bus.write_data);
        end
        // Reset with an accepted write on the port: it must be lost.
        bus.alu_rd = 5'd6; bus.alu_data = 64'h99;
        step();
        idle_inputs();
        vecs++;
        if (bus.reg_write !== 1'b1 || bus.write_register !== 5'd6) begin
            errs++; $display("FAIL inflight: we %b rd %0d required 1 6", bus.reg_write, bus.write_register);
        end
        reset = 1'b1;
        #1;
        vecs++;
        if (bus.reg_write !== 1'b0 || bus.write_data !== 64'd0) begin
            errs++; $display("FAIL mid_run_reset: we %b data %h required 0 0", bus.reg_write, bus.write_data);
        end
        step();
        vecs++;
        if (rf[6] !== 64'd0 || rf[5] !== 64'h77) begin
            errs++; $display("FAIL lost_write: x6 %h x5 %h required 0 77", rf[6], rf[5]);
        end
        run_clear(1'b0);
    endtask

    initial begin
        for (int r = 1; r < 32; r++) rf[r] = 64'hDEAD_BEEF_0000_0000 | 64'(r);
        rf[0] = 64'd0;
        idle_inputs();
        test_reset();
        test_clear();
        test_alu_only();
        test_mem_rd0();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/regfile_wb_ctrl.md
# regfile_wb_ctrl

Write-port controller for the 32 x 64-bit register file (`regfile`). It first sequences a clear of registers x1..x31 after reset, since the register file itself has no reset. It then shares the single write port between the ALU writeback and the load-unit writeback requesters using round-robin arbitration and a valid/ready handshake. A registered output stage drives `reg_write`, `write_register` and `write_data`, and a pending mask is exported for decode hazard logic.

## Interface
- `XLEN`, default 64: data width of `write_data` and the requester data buses.
- `NREG`, default 32: number of architectural registers; register index width is 5.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `alu_valid`  in  1  ALU writeback request.
- `alu_rd`  in  5  ALU destination register.
- `alu_data`  in  XLEN  ALU result.
- `alu_ready`  out  1  ALU request accepted this cycle.
- `mem_valid`  in  1  load writeback request.
- `mem_rd`  in  5  load destination register.
- `mem_data`  in  XLEN  load data.
- `mem_ready`  out  1  load request accepted this cycle.
- `reg_write`  out  1  to regfile write enable.
- `write_register`  out  5  to regfile write address.
- `write_data`  out  XLEN  to regfile write data.
- `init_done`  out  1  clear sequence complete; requests may be accepted.
- `pending_mask`  out  NREG  one-hot bit set for `write_register` while `reg_write`=1.

## Operation
- Two states: CLEAR and RUN.
- Reset (asynchronous, takes effect immediately):
  - state=CLEAR, clear counter=1, last_grant=MEM (so ALU wins the first tie);
  - `reg_write`=0, `write_register`=0, `write_data`=0, `init_done`=0, `pending_mask`=0;
  - `alu_ready`=`mem_ready`=0.
- CLEAR:
  - Each edge loads the output stage with (rd=counter, data=0, write=1), then increments the counter.
  - When the counter reaches 31 that edge issues the last write; state becomes RUN and `init_done` goes to 1 on the same edge.
  - Both ready outputs are 0 throughout CLEAR.
- RUN, grant rule (combinational):
  - Both valid: grant the requester that is not last_grant.
  - One valid: grant it.
  - `x_ready` = RUN & grant_x, so ready may depend on valid.
  - Accept = valid & ready; at most one accept per cycle.
- RUN, on accept:
  - last_grant updates to the accepted requester.
  - rd≠0: the output stage loads (1, rd, data) at the edge.
  - rd=0: the request is consumed and dropped. `reg_write` stays 0 next cycle, but last_grant still updates.
- No accept: the output stage loads `reg_write`=0. `write_register` and `write_data` hold their last values.
- The output stage drains every cycle because the regfile write always completes. Throughput is one write per cycle and nothing is buffered beyond the output stage.
- `pending_mask` = `reg_write` ? (1 << `write_register`) : 0. The mask is registered alongside the output stage.
- Requester obligation: hold rd and data stable while valid is asserted and not yet accepted. A requester that deasserts valid before acceptance has withdrawn its request; no write occurs.

## Timing
- Clear sequence:
  - Reset deasserts before edge E1.
  - Edges E1..E31 write x1..x31 with 0; `reg_write`=1 for 31 consecutive cycles.
  - `init_done`=1 from E31 onward, and ready can first assert in the cycle after E31.
  - The regfile contents are all zero after edge E32.
- Write latency:
  - A request accepted at edge N is presented on the port during cycle N..N+1.
  - The regfile captures it at edge N+1, so the register is readable after N+1.
- `reg_write` is high for exactly one cycle per accepted nonzero-rd request.
- Back-to-back accepts produce back-to-back writes with no bubble.
- Continuous contention alternates ALU, MEM, ALU, ... with no starvation. The maximum wait is 1 cycle.
- Reset mid-CLEAR or mid-RUN:
  - Outputs clear asynchronously and any in-flight write is lost.
  - The clear restarts from x1 after deassertion.
- A request asserted during CLEAR waits (ready=0) and is accepted in the first RUN cycle by the normal grant rule.

## Test plan
- Reset, then idle: exactly 31 writes with `write_register`=1..31 and `write_data`=0 -> `init_done`=1 after the 31st; all read_data is 0 afterwards.
- After init, ALU only: rd=1, data=5, then rd=2, data=6 -> accepted on consecutive edges; `reg_write` pulses for 2 cycles; read_data1/read_data2 show 5/6 one edge after each write.
- Both valid, continuous: ALU rd=3, data=0xA; MEM rd=4, data=0xB -> grants alternate ALU, MEM, ALU; final x3=0xA, x4=0xB; no wait exceeds 1 cycle.
- rd=0 with data=8 from MEM -> `mem_ready`=1 and `reg_write` stays 0; x0 reads 0; the next tie goes to ALU.
- Check `pending_mask` during the rd=4 write -> equals 0x00000010 for that cycle only, and 0 when idle.
- Assert reset at clear step 10 and also mid-stream in RUN -> `reg_write`=0 immediately; a full 31-write clear restarts from x1; an accepted request in flight is not written.
